// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
// Module : sys_defs
// Brief  : Shared fetch/dispatch definitions: IF_ID_PACKET, NOP, queue depth.
// Rev    : 1.0
// ============================================================================
package sys_defs;

    localparam int          DEF_FETCH_Q_DEPTH = 4;
    localparam logic [31:0] NOP_INST          = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } IF_ID_PACKET;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// Module : inst_fifo
// Brief  : Power-of-two circular buffer of IF_ID_PACKETs with flush.
// Rev    : 1.0
// ============================================================================
module inst_fifo
    import sys_defs::*;
#(
    parameter  int DEPTH = DEF_FETCH_Q_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  IF_ID_PACKET   push_data,
    input  logic          pop,
    input  logic          flush,
    output IF_ID_PACKET   head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    IF_ID_PACKET   mem_q [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[tail_q] <= push_data;
    end

    assign head  = mem_q[head_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    a_no_push_full: assert property (@(posedge clock) disable iff (!reset) !(push && full && !flush));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(pop && empty && !flush));

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module : ifetch_queue
// Brief  : Single-outstanding instruction fetch with buffered IF_ID output.
// Rev    : 1.0
// ============================================================================
module ifetch_queue
    import sys_defs::*;
#(
    parameter  int          FETCH_Q_DEPTH = DEF_FETCH_Q_DEPTH,
    parameter  logic [31:0] RESET_PC      = 32'h0000_0000,
    localparam int          CW            = $clog2(FETCH_Q_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          redirect_en,
    input  logic [31:0]   redirect_pc,
    input  logic          dispatch_stall,
    output IF_ID_PACKET   if_id_packet,
    output logic          proc2Imem_req,
    output logic [31:0]   proc2Imem_addr,
    input  logic          Imem2proc_valid,
    input  logic [63:0]   Imem2proc_data,
    output logic [CW-1:0] fq_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push, pop, can_req;
    logic         fifo_empty, fifo_full;
    IF_ID_PACKET  push_data, fifo_head;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        push          = 1'b0;
        can_req       = reset & ~fifo_full & ~redirect_en;
        proc2Imem_req = 1'b0;

        push_data.valid = 1'b1;
        push_data.inst  = fetch_pc_q[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];
        push_data.PC    = fetch_pc_q;
        push_data.NPC   = fetch_pc_q + 32'd4;

        unique case (state_q)
            IDLE: begin
                proc2Imem_req = can_req;
                if (can_req) state_d = WAIT;
            end
            WAIT: begin
                // A response coinciding with a redirect is stale and dropped.
                if (Imem2proc_valid) begin
                    state_d = IDLE;
                    if (!redirect_en) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect_en) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (Imem2proc_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_en) fetch_pc_d = redirect_pc;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign proc2Imem_addr = {fetch_pc_q[31:3], 3'b000};

    always_comb begin
        if_id_packet.valid = 1'b0;
        if_id_packet.inst  = NOP_INST;
        if_id_packet.PC    = 32'h0;
        if_id_packet.NPC   = 32'h0;
        if (!fifo_empty) begin
            if_id_packet       = fifo_head;
            if_id_packet.valid = fifo_head.valid & reset & ~redirect_en;
        end
    end

    assign pop = if_id_packet.valid & ~dispatch_stall;

    inst_fifo #(
        .DEPTH (FETCH_Q_DEPTH)
    ) u_inst_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_en),
        .head      (fifo_head),
        .count     (fq_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch_queue
// Brief  : Directed self-checking bench for ifetch_queue with a latency memory.
// Rev    : 1.0
// ============================================================================
module tb_ifetch_queue;
    import sys_defs::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dispatch_stall = 1'b0;
    IF_ID_PACKET if_id_packet;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic        Imem2proc_valid = 1'b0;
    logic [63:0] Imem2proc_data = 64'h0;
    logic [2:0]  fq_count;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = 32'h0;

    ifetch_queue #(
        .FETCH_Q_DEPTH (4),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .dispatch_stall  (dispatch_stall),
        .if_id_packet    (if_id_packet),
        .proc2Imem_req   (proc2Imem_req),
        .proc2Imem_addr  (proc2Imem_addr),
        .Imem2proc_valid (Imem2proc_valid),
        .Imem2proc_data  (Imem2proc_data),
        .fq_count        (fq_count)
    );

    always #5 clock = ~clock;

    // Instruction word stored at pc: ((pc>>2)+1)<<20 | 0x93 (addi x1,x0,N).
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        logic [31:0] k;
        k = (pc >> 2) + 32'd1;
        return (k << 20) | 32'h0000_0093;
    endfunction

    // Memory model: request seen in cycle R answers in cycle R+lat.
    always @(negedge clock) begin
        #2;
        Imem2proc_valid = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    Imem2proc_valid = 1'b1;
                    Imem2proc_data  = {inst_of(paddr + 32'd4), inst_of(paddr)};
                    pend = 1'b0;
                end
            end
            if (proc2Imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = proc2Imem_addr;
            end
        end
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        redirect_en = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", proc2Imem_req); end
        checks++; if (if_id_packet.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_packet.valid); end
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fq_count); end
        checks++; if (if_id_packet.inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_nop: got %h expected 00000013", if_id_packet.inst); end
        checks++; if (if_id_packet.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_id_packet.PC); end
        reset = 1'b1;
    endtask

    task automatic test_fetch_basic;
        lat = 1;
        dispatch_stall = 1'b0;
        do_reset;
        checks++; if (proc2Imem_req !== 1'b1) begin errors++; $display("FAIL t1_req0: got %b expected 1", proc2Imem_req); end
        checks++; if (proc2Imem_addr !== 32'h0) begin errors++; $display("FAIL t1_addr0: got %h expected 0", proc2Imem_addr); end
        tick;
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t1_wait_req: got %b expected 0", proc2Imem_req); end
        checks++; if (if_id_packet.valid !== 1'b0) begin errors++; $display("FAIL t1_wait_valid: got %b expected 0", if_id_packet.valid); end
        tick;
        checks++; if (if_id_packet.valid !== 1'b1) begin errors++; $display("FAIL t1_p0_valid: got %b expected 1", if_id_packet.valid); end
        checks++; if (if_id_packet.PC !== 32'h0) begin errors++; $display("FAIL t1_p0_pc: got %h expected 0", if_id_packet.PC); end
        checks++; if (if_id_packet.inst !== 32'h0010_0093) begin errors++; $display("FAIL t1_p0_inst: got %h expected 00100093", if_id_packet.inst); end
        checks++; if (if_id_packet.NPC !== 32'h4) begin errors++; $display("FAIL t1_p0_npc: got %h expected 4", if_id_packet.NPC); end
        tick;
        tick;
        checks++; if (if_id_packet.valid !== 1'b1) begin errors++; $display("FAIL t1_p1_valid: got %b expected 1", if_id_packet.valid); end
        checks++; if (if_id_packet.PC !== 32'h4) begin errors++; $display("FAIL t1_p1_pc: got %h expected 4", if_id_packet.PC); end
        checks++; if (if_id_packet.inst !== 32'h0020_0093) begin errors++; $display("FAIL t1_p1_inst: got %h expected 00200093", if_id_packet.inst); end
        checks++; if (if_id_packet.NPC !== 32'h8) begin errors++; $display("FAIL t1_p1_npc: got %h expected 8", if_id_packet.NPC); end
    endtask

    task automatic test_stall_full;
        IF_ID_PACKET first;
        bit          have;
        have  = 1'b0;
        first = '0;
        lat = 1;
        dispatch_stall = 1'b1;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (if_id_packet.valid) begin
                if (!have) begin
                    first = if_id_packet;
                    have  = 1'b1;
                end else begin
                    checks++; if (if_id_packet !== first) begin errors++; $display("FAIL t2_hold: got %h expected %h", if_id_packet, first); end
                end
            end
            if (fq_count == 3'd4) begin
                checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t2_full_req: got %b expected 0", proc2Imem_req); end
            end
        end
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL t2_count: got %0d expected 4", fq_count); end
        checks++; if (first.PC !== 32'h0) begin errors++; $display("FAIL t2_head_pc: got %h expected 0", first.PC); end
        checks++; if (first.inst !== 32'h0010_0093) begin errors++; $display("FAIL t2_head_inst: got %h expected 00100093", first.inst); end
        dispatch_stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_id_packet.valid !== 1'b1) begin errors++; $display("FAIL t2_pop_valid[%0d]: got %b expected 1", i, if_id_packet.valid); end
            checks++; if (if_id_packet.PC !== 32'(i * 4)) begin errors++; $display("FAIL t2_pop_pc[%0d]: got %h expected %h", i, if_id_packet.PC, i * 4); end
            if (i == 3) begin
                checks++; if (fq_count !== 3'd2) begin errors++; $display("FAIL t2_pushpop_count: got %0d expected 2", fq_count); end
            end
            tick;
        end
    endtask

    task automatic test_redirect_drop;
        int          n;
        bit          seen;
        bit          bad;
        logic [31:0] first_pc;
        logic [31:0] first_inst;
        n = 0; seen = 1'b0; bad = 1'b0; first_pc = '0; first_inst = '0;
        lat = 3;
        dispatch_stall = 1'b0;
        do_reset;
        while (!(proc2Imem_req && proc2Imem_addr == 32'h8) && n < 40) begin
            tick;
            n++;
        end
        checks++; if (n >= 40) begin errors++; $display("FAIL t3_wait_req8: got timeout expected request to 8"); end
        tick;
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        #1;
        checks++; if (if_id_packet.valid !== 1'b0) begin errors++; $display("FAIL t3_redir_valid: got %b expected 0", if_id_packet.valid); end
        tick;
        redirect_en = 1'b0;
        #1;
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t3_drop_req: got %b expected 0", proc2Imem_req); end
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL t3_count: got %0d expected 0", fq_count); end
        tick;
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t3_drop_req2: got %b expected 0", proc2Imem_req); end
        tick;
        checks++; if (proc2Imem_req !== 1'b1) begin errors++; $display("FAIL t3_new_req: got %b expected 1", proc2Imem_req); end
        checks++; if (proc2Imem_addr !== 32'h100) begin errors++; $display("FAIL t3_new_addr: got %h expected 100", proc2Imem_addr); end
        for (int i = 0; i < 12; i++) begin
            tick;
            if (if_id_packet.valid) begin
                if (if_id_packet.PC == 32'h8) bad = 1'b1;
                if (!seen) begin
                    seen       = 1'b1;
                    first_pc   = if_id_packet.PC;
                    first_inst = if_id_packet.inst;
                end
            end
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL t3_stale_pkt: got packet PC=8 expected none"); end
        checks++; if (first_pc !== 32'h100) begin errors++; $display("FAIL t3_first_pc: got %h expected 100", first_pc); end
        checks++; if (first_inst !== 32'h0410_0093) begin errors++; $display("FAIL t3_first_inst: got %h expected 04100093", first_inst); end
    endtask

    task automatic test_redirect_resp;
        lat = 1;
        dispatch_stall = 1'b1;
        do_reset;
        for (int i = 0; i < 6; i++) tick;
        checks++; if (fq_count !== 3'd3) begin errors++; $display("FAIL t4_count3: got %0d expected 3", fq_count); end
        checks++; if (proc2Imem_addr !== 32'h8) begin errors++; $display("FAIL t4_req_addr: got %h expected 8", proc2Imem_addr); end
        tick;
        redirect_en = 1'b1;
        redirect_pc = 32'h204;
        #1;
        checks++; if (if_id_packet.valid !== 1'b0) begin errors++; $display("FAIL t4_redir_valid: got %b expected 0", if_id_packet.valid); end
        tick;
        redirect_en = 1'b0;
        #1;
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL t4_flush_count: got %0d expected 0", fq_count); end
        checks++; if (proc2Imem_req !== 1'b1) begin errors++; $display("FAIL t4_req: got %b expected 1", proc2Imem_req); end
        checks++; if (proc2Imem_addr !== 32'h200) begin errors++; $display("FAIL t4_addr: got %h expected 200", proc2Imem_addr); end
        tick;
        tick;
        checks++; if (if_id_packet.valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b expected 1", if_id_packet.valid); end
        checks++; if (if_id_packet.PC !== 32'h204) begin errors++; $display("FAIL t4_pc: got %h expected 204", if_id_packet.PC); end
        checks++; if (if_id_packet.inst !== 32'h0820_0093) begin errors++; $display("FAIL t4_inst_hi: got %h expected 08200093", if_id_packet.inst); end
        checks++; if (if_id_packet.NPC !== 32'h208) begin errors++; $display("FAIL t4_npc: got %h expected 208", if_id_packet.NPC); end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        lat = 3;
        dispatch_stall = 1'b1;
        do_reset;
        while (!(proc2Imem_req && fq_count == 3'd2) && n < 40) begin
            tick;
            n++;
        end
        checks++; if (n >= 40) begin errors++; $display("FAIL t5_wait: got timeout expected request with 2 queued"); end
        tick;
        checks++; if (fq_count !== 3'd2) begin errors++; $display("FAIL t5_pre_count: got %0d expected 2", fq_count); end
        reset = 1'b0;
        tick;
        checks++; if (if_id_packet.valid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b expected 0", if_id_packet.valid); end
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL t5_count: got %0d expected 0", fq_count); end
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t5_req: got %b expected 0", proc2Imem_req); end
        reset = 1'b1;
        #1;
        checks++; if (proc2Imem_req !== 1'b1) begin errors++; $display("FAIL t5_rel_req: got %b expected 1", proc2Imem_req); end
        checks++; if (proc2Imem_addr !== 32'h0) begin errors++; $display("FAIL t5_rel_addr: got %h expected 0", proc2Imem_addr); end
    endtask

    task automatic test_pc_wrap;
        lat = 1;
        dispatch_stall = 1'b1;
        do_reset;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (proc2Imem_req !== 1'b0) begin errors++; $display("FAIL t6_redir_req: got %b expected 0", proc2Imem_req); end
        tick;
        redirect_en = 1'b0;
        #1;
        checks++; if (proc2Imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL t6_addr: got %h expected fffffff8", proc2Imem_addr); end
        tick;
        tick;
        checks++; if (if_id_packet.PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t6_pc: got %h expected fffffffc", if_id_packet.PC); end
        checks++; if (if_id_packet.NPC !== 32'h0) begin errors++; $display("FAIL t6_npc: got %h expected 0", if_id_packet.NPC); end
        checks++; if (if_id_packet.inst !== 32'h0000_0093) begin errors++; $display("FAIL t6_inst: got %h expected 00000093", if_id_packet.inst); end
        checks++; if (proc2Imem_addr !== 32'h0) begin errors++; $display("FAIL t6_wrap_addr: got %h expected 0", proc2Imem_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_fetch_basic;
        test_stall_full;
        test_redirect_drop;
        test_redirect_resp;
        test_reset_mid;
        test_pc_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
